// File: rtl/modulo_tabuleiro_param.sv
// -----------------------------------------------------------------------------
// modulo_tabuleiro_param
//
// Parametrised battleship board: ship and attack maps of ROWS x COLS cells,
// a POSITION -> ATTACK -> END game FSM with ship/hit/shot counters and a shot
// limit, and a column-scanned LED matrix driver.
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-high reset (clears the whole game)
//   btn_confirm  raw level; rising edge toggles a ship (POSITION) or fires (ATTACK)
//   btn_start    raw level; rising edge advances the game phase
//   row_sel      target row    (values >= ROWS are invalid)
//   col_sel      target column (values >= COLS are invalid)
//   m_col        one-hot active-high column drive
//   m_line       row data for the active column
//   state        00 POSITION, 01 ATTACK, 10 END
//   ship_cnt     ships placed
//   hit_cnt      hits scored
//   shot_cnt     valid shots fired
//   last_res     00 none, 01 miss, 10 hit, 11 repeat/invalid
//   win          high in END when every ship was hit
// -----------------------------------------------------------------------------
module modulo_tabuleiro_param #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int SCAN_DIV  = 16,
  parameter int MAX_SHOTS = 12,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(ROWS*COLS+1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            btn_confirm,
  input  logic            btn_start,
  input  logic [RW-1:0]   row_sel,
  input  logic [CW-1:0]   col_sel,
  output logic [COLS-1:0] m_col,
  output logic [ROWS-1:0] m_line,
  output logic [1:0]      state,
  output logic [NW-1:0]   ship_cnt,
  output logic [NW-1:0]   hit_cnt,
  output logic [NW-1:0]   shot_cnt,
  output logic [1:0]      last_res,
  output logic            win
);

  localparam int CELLS = ROWS*COLS;
  localparam int IW    = $clog2(CELLS);

  localparam logic [1:0] ST_POS = 2'b00;
  localparam logic [1:0] ST_ATK = 2'b01;
  localparam logic [1:0] ST_END = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_BAD  = 2'b11;

  localparam logic [NW-1:0] CELLS_N  = NW'(CELLS);
  localparam logic [NW-1:0] MAX_N    = NW'(MAX_SHOTS);
  localparam logic [RW:0]   ROWS_L   = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_L   = (CW+1)'(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);

  // ---------------------------------------------------------------------------
  // Button conditioning: two synchroniser stages, one edge-history stage and a
  // registered pulse. Index 0 = confirm, index 1 = start.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [2:0] sync_reg [2];
  logic [1:0] pulse_reg;
  logic       conf_p;
  logic       start_p;

  assign btn_raw = {btn_start, btn_confirm};
  assign conf_p  = pulse_reg[0];
  assign start_p = pulse_reg[1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        sync_reg[i] <= '0;
      end
      pulse_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_reg[i]  <= {sync_reg[i][1:0], btn_raw[i]};
        pulse_reg[i] <= sync_reg[i][1] & ~sync_reg[i][2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  logic [CELLS-1:0] ship_reg, ship_next;
  logic [CELLS-1:0] atk_reg,  atk_next;
  logic [1:0]       state_reg, state_next;
  logic [NW-1:0]    ship_cnt_reg, ship_cnt_next;
  logic [NW-1:0]    hit_cnt_reg,  hit_cnt_next;
  logic [NW-1:0]    shot_cnt_reg, shot_cnt_next;
  logic [1:0]       last_res_reg, last_res_next;
  logic             win_reg, win_next;

  logic             coord_ok;
  logic [IW-1:0]    cell_idx;

  assign coord_ok = ({1'b0, row_sel} < ROWS_L) && ({1'b0, col_sel} < COLS_L);
  // Only meaningful when coord_ok; out-of-range values are never used to index.
  assign cell_idx = IW'(32'(row_sel) * COLS + 32'(col_sel));

  always_comb begin
    ship_next     = ship_reg;
    atk_next      = atk_reg;
    state_next    = state_reg;
    ship_cnt_next = ship_cnt_reg;
    hit_cnt_next  = hit_cnt_reg;
    shot_cnt_next = shot_cnt_reg;
    last_res_next = last_res_reg;
    win_next      = win_reg;

    // Start wins over a coincident confirm; the confirm is simply dropped.
    if (start_p) begin
      case (state_reg)
        ST_POS: begin
          if (ship_cnt_reg != '0) begin
            state_next    = ST_ATK;
            atk_next      = '0;
            hit_cnt_next  = '0;
            shot_cnt_next = '0;
            last_res_next = RES_NONE;
          end
        end
        ST_END: begin
          state_next    = ST_POS;
          ship_next     = '0;
          atk_next      = '0;
          ship_cnt_next = '0;
          hit_cnt_next  = '0;
          shot_cnt_next = '0;
          last_res_next = RES_NONE;
          win_next      = 1'b0;
        end
        default: ;
      endcase
    end else if (conf_p && (state_reg == ST_POS || state_reg == ST_ATK)) begin
      if (!coord_ok) begin
        last_res_next = RES_BAD;
      end else if (state_reg == ST_POS) begin
        if (ship_reg[cell_idx]) begin
          ship_next[cell_idx] = 1'b0;
          if (ship_cnt_reg != '0) begin
            ship_cnt_next = ship_cnt_reg - 1'b1;
          end
        end else begin
          ship_next[cell_idx] = 1'b1;
          if (ship_cnt_reg != CELLS_N) begin
            ship_cnt_next = ship_cnt_reg + 1'b1;
          end
        end
      end else begin
        if (atk_reg[cell_idx]) begin
          last_res_next = RES_BAD;
        end else begin
          atk_next[cell_idx] = 1'b1;
          shot_cnt_next      = shot_cnt_reg + 1'b1;
          if (ship_reg[cell_idx]) begin
            hit_cnt_next  = hit_cnt_reg + 1'b1;
            last_res_next = RES_HIT;
          end else begin
            last_res_next = RES_MISS;
          end
          // End-of-game decision uses the freshly updated counts; a win on the
          // final permitted shot still counts as a win.
          if (hit_cnt_next == ship_cnt_reg) begin
            state_next = ST_END;
            win_next   = 1'b1;
          end else if (shot_cnt_next == MAX_N) begin
            state_next = ST_END;
            win_next   = 1'b0;
          end
        end
      end
    end

    // The unused encoding falls back to POSITION.
    if (state_reg == 2'b11) begin
      state_next = ST_POS;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ship_reg     <= '0;
      atk_reg      <= '0;
      state_reg    <= ST_POS;
      ship_cnt_reg <= '0;
      hit_cnt_reg  <= '0;
      shot_cnt_reg <= '0;
      last_res_reg <= RES_NONE;
      win_reg      <= 1'b0;
    end else begin
      ship_reg     <= ship_next;
      atk_reg      <= atk_next;
      state_reg    <= state_next;
      ship_cnt_reg <= ship_cnt_next;
      hit_cnt_reg  <= hit_cnt_next;
      shot_cnt_reg <= shot_cnt_next;
      last_res_reg <= last_res_next;
      win_reg      <= win_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Matrix scan
  // ---------------------------------------------------------------------------
  logic [SCAN_DIV-1:0] presc_reg;
  logic [CW-1:0]       col_idx_reg, col_idx_next;
  logic [COLS-1:0]     m_col_reg;
  logic [ROWS-1:0]     m_line_reg, m_line_next;
  logic [CELLS-1:0]    src_map;
  logic                scan_tick;

  // Tick on the cycle the prescaler wraps back to zero.
  assign scan_tick = &presc_reg;

  always_comb begin
    col_idx_next = col_idx_reg;
    if (scan_tick) begin
      col_idx_next = (col_idx_reg == COL_LAST) ? '0 : col_idx_reg + 1'b1;
    end
  end

  always_comb begin
    case (state_reg)
      ST_POS:  src_map = ship_reg;
      ST_ATK:  src_map = atk_reg;
      // END blinks between hits only and the full fleet.
      ST_END:  src_map = presc_reg[SCAN_DIV-1] ? ship_reg : (ship_reg & atk_reg);
      default: src_map = ship_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] row_bits;
      assign row_bits        = src_map[gi*COLS +: COLS];
      assign m_line_next[gi] = row_bits[col_idx_reg];
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_reg   <= '0;
      col_idx_reg <= '0;
      m_col_reg   <= COLS'(1);
      m_line_reg  <= '0;
    end else begin
      presc_reg   <= presc_reg + 1'b1;
      col_idx_reg <= col_idx_next;
      m_col_reg   <= COLS'(1) << col_idx_reg;
      m_line_reg  <= m_line_next;
    end
  end

  assign m_col    = m_col_reg;
  assign m_line   = m_line_reg;
  assign state    = state_reg;
  assign ship_cnt = ship_cnt_reg;
  assign hit_cnt  = hit_cnt_reg;
  assign shot_cnt = shot_cnt_reg;
  assign last_res = last_res_reg;
  assign win      = win_reg;

endmodule

// File: tb/tb_modulo_tabuleiro_param.sv
// -----------------------------------------------------------------------------
// tb_modulo_tabuleiro_param
//
// Two instances: A (7x5, fast scan, shot limit 3) and B (8x8, fast scan).
// Every button transaction runs a reference game model that pushes the
// expected outputs to a queue; once the DUT has settled the entry is popped
// and compared. One line is printed per transaction.
// -----------------------------------------------------------------------------
module tb_modulo_tabuleiro_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic       a_conf, a_start;
  logic [2:0] a_row, a_col;
  logic [4:0] a_m_col;
  logic [6:0] a_m_line;
  logic [1:0] a_state, a_lr;
  logic [5:0] a_ship, a_hit, a_shot;
  logic       a_win;

  logic       b_conf, b_start;
  logic [2:0] b_row, b_col;
  logic [7:0] b_m_col, b_m_line;
  logic [1:0] b_state, b_lr;
  logic [6:0] b_ship, b_hit, b_shot;
  logic       b_win;

  modulo_tabuleiro_param #(.ROWS(7), .COLS(5), .SCAN_DIV(2), .MAX_SHOTS(3)) dut_a (
    .clk(clk), .clr(clr), .btn_confirm(a_conf), .btn_start(a_start),
    .row_sel(a_row), .col_sel(a_col), .m_col(a_m_col), .m_line(a_m_line),
    .state(a_state), .ship_cnt(a_ship), .hit_cnt(a_hit), .shot_cnt(a_shot),
    .last_res(a_lr), .win(a_win)
  );

  modulo_tabuleiro_param #(.ROWS(8), .COLS(8), .SCAN_DIV(2), .MAX_SHOTS(12)) dut_b (
    .clk(clk), .clr(clr), .btn_confirm(b_conf), .btn_start(b_start),
    .row_sel(b_row), .col_sel(b_col), .m_col(b_m_col), .m_line(b_m_line),
    .state(b_state), .ship_cnt(b_ship), .hit_cnt(b_hit), .shot_cnt(b_shot),
    .last_res(b_lr), .win(b_win)
  );

  typedef struct {
    int d;
    int st;
    int ship;
    int hit;
    int shot;
    int lr;
    int win;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference game model.
  bit m_ship [2][64];
  bit m_atk  [2][64];
  int m_st[2], m_n[2], m_hit[2], m_shot[2], m_lr[2], m_win[2];

  function automatic int rows_of(input int d); return (d != 0) ? 8 : 7; endfunction
  function automatic int cols_of(input int d); return (d != 0) ? 8 : 5; endfunction
  function automatic int max_of(input int d);  return (d != 0) ? 12 : 3; endfunction

  task automatic model(input int d, input bit cf, input bit st, input int r, input int c);
    int  idx;
    bit  ok;
    exp_t e;
    ok  = (r < rows_of(d)) && (c < cols_of(d));
    idx = r * cols_of(d) + c;
    if (st) begin
      if (m_st[d] == 0 && m_n[d] > 0) begin
        m_st[d] = 1; m_hit[d] = 0; m_shot[d] = 0; m_lr[d] = 0;
        for (int i = 0; i < 64; i++) m_atk[d][i] = 1'b0;
      end else if (m_st[d] == 2) begin
        m_st[d] = 0; m_n[d] = 0; m_hit[d] = 0; m_shot[d] = 0; m_lr[d] = 0; m_win[d] = 0;
        for (int i = 0; i < 64; i++) begin
          m_ship[d][i] = 1'b0;
          m_atk[d][i]  = 1'b0;
        end
      end
    end else if (cf && m_st[d] != 2) begin
      if (!ok) begin
        m_lr[d] = 3;
      end else if (m_st[d] == 0) begin
        if (m_ship[d][idx]) begin m_ship[d][idx] = 1'b0; m_n[d]--; end
        else                begin m_ship[d][idx] = 1'b1; m_n[d]++; end
      end else if (m_atk[d][idx]) begin
        m_lr[d] = 3;
      end else begin
        m_atk[d][idx] = 1'b1;
        m_shot[d]++;
        if (m_ship[d][idx]) begin m_hit[d]++; m_lr[d] = 2; end
        else m_lr[d] = 1;
        if (m_hit[d] == m_n[d]) begin m_st[d] = 2; m_win[d] = 1; end
        else if (m_shot[d] == max_of(d)) begin m_st[d] = 2; m_win[d] = 0; end
      end
    end
    e.d = d; e.st = m_st[d]; e.ship = m_n[d]; e.hit = m_hit[d];
    e.shot = m_shot[d]; e.lr = m_lr[d]; e.win = m_win[d];
    exp_q.push_back(e);
  endtask

  task automatic get_out(input int d, output int st, output int ship, output int hit,
                         output int shot, output int lr, output int w);
    if (d == 0) begin
      st = int'(a_state); ship = int'(a_ship); hit = int'(a_hit);
      shot = int'(a_shot); lr = int'(a_lr); w = int'(a_win);
    end else begin
      st = int'(b_state); ship = int'(b_ship); hit = int'(b_hit);
      shot = int'(b_shot); lr = int'(b_lr); w = int'(b_win);
    end
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    int st, ship, hit, shot, lr, w;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      get_out(e.d, st, ship, hit, shot, lr, w);
      chk({tag, ".state"}, st, e.st);
      chk({tag, ".ship"},  ship, e.ship);
      chk({tag, ".hit"},   hit, e.hit);
      chk({tag, ".shot"},  shot, e.shot);
      chk({tag, ".res"},   lr, e.lr);
      chk({tag, ".win"},   w, e.win);
      $display("txn %-18s dut=%0d state=%0d ship=%0d hit=%0d shot=%0d res=%0d win=%0d",
               tag, e.d, st, ship, hit, shot, lr, w);
    end
  endtask

  task automatic press(input int d, input int r, input int c, input bit cf,
                       input bit st, input int hold, input string tag);
    @(negedge clk);
    model(d, cf, st, r, c);
    if (d == 0) begin a_row = 3'(r); a_col = 3'(c); a_conf = cf; a_start = st; end
    else        begin b_row = 3'(r); b_col = 3'(c); b_conf = cf; b_start = st; end
    repeat (hold) @(negedge clk);
    a_conf = 1'b0; a_start = 1'b0; b_conf = 1'b0; b_start = 1'b0;
    repeat (6) @(negedge clk);
    sb_compare(tag);
  endtask

  // Returns at the negedge sample where the column drive equals val.
  task automatic wait_col(input int d, input int val, input int budget, input string tag);
    int found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((d == 0) ? int'(a_m_col) : int'(b_m_col)) == val) begin
        found = 1;
        break;
      end
    end
    chk({tag, ".found"}, found, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    clr = 1'b1;
    a_conf = 0; a_start = 0; a_row = 0; a_col = 0;
    b_conf = 0; b_start = 0; b_row = 0; b_col = 0;
    repeat (3) @(negedge clk);
    clr = 1'b0;

    // Let the scan run, then reset asynchronously between clock edges.
    repeat (7) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("rst.a_m_col", int'(a_m_col), 1);
    chk("rst.a_m_line", int'(a_m_line), 0);
    chk("rst.a_state", int'(a_state), 0);
    chk("rst.a_ship", int'(a_ship), 0);
    chk("rst.a_res", int'(a_lr), 0);
    chk("rst.b_m_col", int'(b_m_col), 1);
    @(negedge clk);
    clr = 1'b0;

    // One column step every 4 cycles; A wraps after 5, B after 8.
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("scan_a.%0d", n), int'(a_m_col), 1 << (((n - 1) / 4) % 5));
      chk($sformatf("scan_b.%0d", n), int'(b_m_col), 1 << (((n - 1) / 4) % 8));
    end

    press(0, 0, 0, 0, 1, 5, "start_empty");
    press(0, 0, 0, 1, 0, 5, "place00");
    press(0, 2, 3, 1, 0, 5, "place23");
    press(0, 6, 4, 1, 0, 5, "place64");
    press(0, 2, 3, 1, 0, 5, "unplace23");
    chk("placed.ship", int'(a_ship), 2);
    wait_col(0, 1, 40, "col0");
    chk("col0.line", int'(a_m_line), 7'b0000001);
    wait_col(0, 16, 40, "col4");
    chk("col4.line", int'(a_m_line), 7'b1000000);
    press(0, 7, 0, 1, 0, 5, "bad_row");

    press(0, 0, 0, 0, 1, 5, "start_game");
    press(0, 1, 1, 1, 0, 5, "miss11");
    press(0, 0, 0, 1, 0, 5, "hit00");
    press(0, 0, 0, 1, 0, 5, "repeat00");
    press(0, 6, 4, 1, 0, 5, "win64");
    chk("win.state", int'(a_state), 2);
    chk("win.win", int'(a_win), 1);
    chk("win.shot", int'(a_shot), 3);

    press(0, 0, 0, 0, 1, 5, "end_to_pos");
    wait_col(0, 1, 40, "clear0");
    chk("clear0.line", int'(a_m_line), 0);

    press(0, 0, 0, 1, 0, 5, "place00b");
    press(0, 0, 0, 0, 1, 5, "start_loss");
    press(0, 1, 1, 1, 0, 5, "miss11b");
    press(0, 1, 2, 1, 0, 5, "miss12");
    press(0, 1, 3, 1, 0, 5, "miss13");
    chk("loss.state", int'(a_state), 2);
    chk("loss.win", int'(a_win), 0);
    // END display alternates hits (none) and the fleet (row 0).
    wait_col(0, 1, 40, "blink");
    seen = 1 << int'(a_m_line[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen |= 1 << int'(a_m_line[0]);
    end
    chk("blink.both", seen, 3);
    press(0, 0, 0, 1, 0, 5, "end_conf_ignored");
    press(0, 0, 0, 0, 1, 5, "loss_to_pos");
    wait_col(0, 1, 40, "clear1");
    chk("clear1.line", int'(a_m_line), 0);

    press(0, 3, 3, 1, 0, 1000, "hold1000");
    chk("hold.ship", int'(a_ship), 1);
    press(0, 4, 4, 1, 1, 5, "conf_and_start");
    press(0, 3, 3, 1, 0, 5, "hit33");

    for (int k = 0; k < 8; k++) begin
      wait_col(1, 1 << k, 40, $sformatf("b_col%0d", k));
    end
    press(1, 7, 7, 1, 0, 5, "b_place77");
    wait_col(1, 128, 40, "b_col7");
    chk("b_col7.line", int'(b_m_line), 128);
    press(1, 0, 0, 0, 1, 5, "b_start");
    press(1, 7, 7, 1, 0, 5, "b_hit77");

    // Mid-game reset on A discards everything.
    press(0, 0, 0, 0, 1, 5, "a_new_round");
    press(0, 1, 1, 1, 0, 5, "a_place11");
    press(0, 0, 0, 0, 1, 5, "a_start2");
    press(0, 2, 2, 1, 0, 5, "a_miss22");
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("midrst.state", int'(a_state), 0);
    chk("midrst.ship", int'(a_ship), 0);
    chk("midrst.shot", int'(a_shot), 0);
    chk("midrst.res", int'(a_lr), 0);
    chk("midrst.b_win", int'(b_win), 0);
    @(negedge clk);
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/modulo_tabuleiro_param.md
Name: modulo_tabuleiro_param

Overview:
- Parametrised successor of the fixed 7x5 battleship board logic.
- Holds ship-position and attack maps as ROWS x COLS register arrays.
- Runs a POSITION -> ATTACK -> END game FSM with hit, shot and ship counting and a configurable shot limit.
- Drives a column-scanned LED matrix directly; sits between the debounced board buttons/switches and the matrix pins.

Parameters:
ROWS, 7, matrix rows (2..16)
COLS, 5, matrix columns (2..16)
SCAN_DIV, 16, prescaler width; one column-advance tick every 2^SCAN_DIV clk cycles
MAX_SHOTS, 12, shot limit in ATTACK before loss (1..ROWS*COLS)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
btn_confirm  in  1  level, asynchronous to clk; rising edge = toggle ship (POSITION) / fire (ATTACK)
btn_start  in  1  level, asynchronous; rising edge = advance phase
row_sel  in  RW  target row, RW=$clog2(ROWS)
col_sel  in  CW  target column, CW=$clog2(COLS)
m_col  out  COLS  one-hot active-high column drive
m_line  out  ROWS  row data for the active column
state  out  2  00 POSITION, 01 ATTACK, 10 END
ship_cnt  out  NW  ships placed, NW=$clog2(ROWS*COLS+1)
hit_cnt  out  NW  hits scored
shot_cnt  out  NW  valid shots fired
last_res  out  2  00 none, 01 miss, 10 hit, 11 repeat/invalid
win  out  1  high in END when all ships were hit

Behaviour:
- Reset: clr=1 forces the following immediately, independent of clk.
  - Both maps = 0; state = POSITION; prescaler = 0; column index = 0.
  - m_col = 1 (bit 0); m_line = 0; all counters = 0; last_res = 00; win = 0.
- Reset mid-game discards all progress.
- Input conditioning:
  - Each button passes a 2-FF synchroniser plus an edge register.
  - A raw rising edge held at least 3 clk cycles yields exactly one 1-cycle pulse.
  - Pulse appears 3 cycles after the first sampling edge.
  - Holding a button produces no further pulses.
- Coordinates: row_sel >= ROWS or col_sel >= COLS is invalid.
  - Confirm pulse with invalid coordinates: no map or counter change; last_res = 11.
- POSITION:
  - Confirm pulse toggles ship[row][col].
  - ship_cnt increments when setting a cell and decrements when clearing it.
  - ship_cnt never wraps; bounded 0..ROWS*COLS.
  - Start pulse with ship_cnt > 0 -> ATTACK; hit_cnt = shot_cnt = 0, last_res = 00.
  - Start pulse with ship_cnt = 0 is ignored.
- ATTACK:
  - Confirm pulse on an already-attacked cell: no count change; last_res = 11.
  - Otherwise: set atk[row][col]; shot_cnt += 1.
    - If ship bit set: hit_cnt += 1, last_res = 10.
    - Else: last_res = 01.
  - Counters and last_res update on the clk edge after the pulse cycle.
  - Same edge as the last update: hit_cnt == ship_cnt -> END with win = 1.
  - Else if shot_cnt == MAX_SHOTS -> END with win = 0.
  - Win check has priority over the shot limit.
  - Start pulse in ATTACK is ignored.
- END:
  - Confirm pulses are ignored.
  - Start pulse clears both maps and all counters, sets win = 0 and last_res = 00 -> POSITION.
- Simultaneous confirm and start pulses in the same cycle: start is processed, confirm is dropped.
- Display scan:
  - Free-running SCAN_DIV-bit prescaler; tick on wrap to 0.
  - Column index advances on each tick, COLS-1 -> 0 wrap.
  - m_col = one-hot(column index); registered, 1-cycle lag from the index.
  - m_line[r] is registered from the source map at (r, column index):
    - POSITION: ship map.
    - ATTACK: attack map.
    - END: ship AND attack (hits) while prescaler MSB = 0, ship map while MSB = 1 (blink).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and scan, SCAN_DIV=2, ROWS=7, COLS=5:
  - Assert clr mid-scan -> m_col=00001, m_line=0, state=00 immediately.
  - After release, m_col steps 00001 -> 00010 -> ... -> 10000 -> 00001, one step every 4 cycles.
- Placement:
  - Place (0,0), (2,3), (6,4); toggle (2,3) off -> ship_cnt=2.
  - When column 0 is active, m_line=0000001.
  - Confirm with row_sel=7 -> last_res=11, ship_cnt unchanged.
  - Start with ship_cnt=0 -> state stays 00.
- Win:
  - Ships at (0,0), (6,4); start; fire (1,1) -> last_res=01, shot_cnt=1.
  - Fire (0,0) -> 10, hit_cnt=1.
  - Fire (0,0) again -> 11, shot_cnt stays 2.
  - Fire (6,4) -> state=10, win=1, hit_cnt=2, shot_cnt=3.
- Loss, MAX_SHOTS=3:
  - Three distinct misses -> state=10, win=0, shot_cnt=3.
  - Further confirms are ignored.
  - Start -> state=00, all counts 0, maps 0.
- Input conditioning and priority:
  - Button held for 1000 cycles -> exactly one toggle.
  - Confirm and start rising on the same cycle in POSITION with ship_cnt=1 -> state=01, ship map unchanged.
- Parameter sweep: ROWS=8, COLS=8 -> m_col cycles through 8 one-hot values; a ship at (7,7) is fully playable.
